// File: rtl/ofdm_symbol_scheduler.sv
// ofdm_symbol_scheduler
// Arbitrates two Avalon-ST sample channels onto one source, one OFDM symbol
// packet at a time, enforcing a fixed packet length of PKT_WORDS words.
// Ports:
//   clock_clk, reset_reset_n      - clock, async active-low reset
//   asi_in0_* / asi_in1_*         - Avalon-ST sinks (data, valid, sop, eop, ready)
//   aso_out0_*                    - Avalon-ST source, data = {word, channel id}
//   enable                        - permits new grants
//   busy, pkt_count, err_count    - status
module ofdm_symbol_scheduler #(
  parameter int unsigned PKT_WORDS = 36
) (
  input  logic        clock_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] asi_in0_data,
  input  logic        asi_in0_valid,
  input  logic        asi_in0_startofpacket,
  input  logic        asi_in0_endofpacket,
  output logic        asi_in0_ready,
  input  logic [31:0] asi_in1_data,
  input  logic        asi_in1_valid,
  input  logic        asi_in1_startofpacket,
  input  logic        asi_in1_endofpacket,
  output logic        asi_in1_ready,
  output logic [32:0] aso_out0_data,
  output logic        aso_out0_valid,
  output logic        aso_out0_startofpacket,
  output logic        aso_out0_endofpacket,
  input  logic        aso_out0_ready,
  input  logic        enable,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic [7:0]  err_count
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ERR_W = 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_WORDS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [15:0]      pkt_count_q;
  logic [ERR_W-1:0] err_count_q;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             out_en_q;
  logic             pkt_inc, err_inc;
  logic             rdy0, rdy1;
  logic             out_valid, out_sop, out_eop;
  logic             sel_valid, sel_eop;
  logic [31:0]      sel_data;
  logic             req0, req1, last_word;

  // Mux of the granted sink
  assign sel_valid = grant_q ? asi_in1_valid       : asi_in0_valid;
  assign sel_eop   = grant_q ? asi_in1_endofpacket : asi_in0_endofpacket;
  assign sel_data  = grant_q ? asi_in1_data        : asi_in0_data;
  assign req0      = asi_in0_valid && asi_in0_startofpacket;
  assign req1      = asi_in1_valid && asi_in1_startofpacket;
  assign last_word = (word_cnt_q == LAST_IDX);

  // Next-state, handshake and counter-strobe logic. out_en_q holds every
  // handshake low while in reset and for the first edge after release.
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_inc      = 1'b0;
    err_inc      = 1'b0;
    rdy0         = 1'b0;
    rdy1         = 1'b0;
    out_valid    = 1'b0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    if (out_en_q) begin
      case (state_q)
        IDLE: begin
          // Words without sop are drained and counted as errors
          rdy0    = asi_in0_valid && !asi_in0_startofpacket;
          rdy1    = asi_in1_valid && !asi_in1_startofpacket;
          err_inc = rdy0 || rdy1;
          if (enable && (req0 || req1)) begin
            grant_d      = (req0 && req1) ? !last_grant_q : req1;
            last_grant_d = grant_d;
            word_cnt_d   = '0;
            state_d      = XFER;
          end
        end
        XFER: begin
          out_valid = sel_valid;
          out_sop   = (word_cnt_q == '0);
          out_eop   = last_word || sel_eop;
          if (grant_q) rdy1 = aso_out0_ready;
          else         rdy0 = aso_out0_ready;
          if (sel_valid && aso_out0_ready) begin
            if (sel_eop) begin
              state_d = IDLE;
              if (last_word) pkt_inc = 1'b1;
              else           err_inc = 1'b1;
            end else if (last_word) begin
              // Overlong packet: truncate here, drop the tail in FLUSH
              state_d = FLUSH;
              err_inc = 1'b1;
            end else begin
              word_cnt_d = word_cnt_q + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          if (grant_q) rdy1 = 1'b1;
          else         rdy0 = 1'b1;
          if (sel_valid && sel_eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and status registers
  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      pkt_count_q  <= '0;
      err_count_q  <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      out_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_en_q     <= 1'b1;
      if (pkt_inc) pkt_count_q <= pkt_count_q + 16'(1);
      if (err_inc && (err_count_q != ERR_MAX)) err_count_q <= err_count_q + ERR_W'(1);
    end
  end

  assign asi_in0_ready          = rdy0;
  assign asi_in1_ready          = rdy1;
  assign aso_out0_data          = {sel_data, grant_q};
  assign aso_out0_valid         = out_valid;
  assign aso_out0_startofpacket = out_sop;
  assign aso_out0_endofpacket   = out_eop;
  assign busy                   = (state_q != IDLE);
  assign pkt_count              = pkt_count_q;
  assign err_count              = err_count_q;

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// tb_ofdm_symbol_scheduler
// Scoreboard bench: each packet's expected output words are queued when it is
// sent, and popped as the DUT source completes handshakes.
module tb_ofdm_symbol_scheduler;

  localparam int PKT = 36;

  typedef struct packed {
    logic [32:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  logic        clock_clk = 1'b0;
  logic        reset_reset_n;
  logic [31:0] in_data [2];
  logic [1:0]  in_valid, in_sop, in_eop, in_ready;
  logic [32:0] aso_out0_data;
  logic        aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket;
  logic        aso_out0_ready;
  logic        enable, busy;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_pkt  = 0;
  int   exp_err  = 0;
  logic rdy_mode = 1'b0;

  ofdm_symbol_scheduler #(.PKT_WORDS(PKT)) dut (
    .clock_clk              (clock_clk),
    .reset_reset_n          (reset_reset_n),
    .asi_in0_data           (in_data[0]),
    .asi_in0_valid          (in_valid[0]),
    .asi_in0_startofpacket  (in_sop[0]),
    .asi_in0_endofpacket    (in_eop[0]),
    .asi_in0_ready          (in_ready[0]),
    .asi_in1_data           (in_data[1]),
    .asi_in1_valid          (in_valid[1]),
    .asi_in1_startofpacket  (in_sop[1]),
    .asi_in1_endofpacket    (in_eop[1]),
    .asi_in1_ready          (in_ready[1]),
    .aso_out0_data          (aso_out0_data),
    .aso_out0_valid         (aso_out0_valid),
    .aso_out0_startofpacket (aso_out0_startofpacket),
    .aso_out0_endofpacket   (aso_out0_endofpacket),
    .aso_out0_ready         (aso_out0_ready),
    .enable                 (enable),
    .busy                   (busy),
    .pkt_count              (pkt_count),
    .err_count              (err_count)
  );

  always #5 clock_clk = ~clock_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_word(input int ch, input int tag, input int i);
    return {4'(ch), 12'(tag), 16'(i)};
  endfunction

  // Expected output of an n-word packet: truncated to PKT words, eop on last
  task automatic push_exp(input int ch, input int tag, input int n);
    int k;
    exp_t e;
    k = (n < PKT) ? n : PKT;
    for (int i = 0; i < k; i++) begin
      e.data = {mk_word(ch, tag, i), 1'(ch)};
      e.sop  = (i == 0);
      e.eop  = (i == k - 1);
      exp_q.push_back(e);
    end
  endtask

  // Present one word and hold it until the sink accepts it
  task automatic send_word(input int ch, input logic [31:0] d, input logic s, input logic e);
    logic acc;
    int   cyc;
    in_valid[ch] = 1'b1;
    in_data[ch]  = d;
    in_sop[ch]   = s;
    in_eop[ch]   = e;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 3000) begin
      @(negedge clock_clk);
      acc = in_ready[ch];
      @(posedge clock_clk);
      #1;
      cyc++;
    end
    if (!acc) check("handshake_timeout", 64'(acc), 64'(1));
  endtask

  task automatic release_ch(input int ch);
    in_valid[ch] = 1'b0;
    in_sop[ch]   = 1'b0;
    in_eop[ch]   = 1'b0;
  endtask

  task automatic send_pkt(input int ch, input int tag, input int n);
    for (int i = 0; i < n; i++)
      send_word(ch, mk_word(ch, tag, i), 1'(i == 0), 1'(i == n - 1));
    release_ch(ch);
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clock_clk);
      cyc++;
    end
    repeat (3) @(posedge clock_clk);
    #1;
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkt));
    check({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(aso_out0_valid), 64'(0));
    check({tag, "_out_sop"}, 64'(aso_out0_startofpacket), 64'(0));
    check({tag, "_out_eop"}, 64'(aso_out0_endofpacket), 64'(0));
    check({tag, "_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_pkt_count"}, 64'(pkt_count), 64'(0));
    check({tag, "_err_count"}, 64'(err_count), 64'(0));
  endtask

  task automatic pulse_reset();
    @(posedge clock_clk);
    #1;
    reset_reset_n = 1'b0;
    exp_pkt = 0;
    exp_err = 0;
    repeat (2) @(posedge clock_clk);
    #1;
    reset_reset_n = 1'b1;
    repeat (2) @(posedge clock_clk);
    #1;
  endtask

  initial begin
    reset_reset_n = 1'b0;
    enable = 1'b1;
    in_data[0] = '0;
    in_data[1] = '0;
    in_valid = '0;
    in_sop = '0;
    in_eop = '0;

    fork
      // Output ready pattern: constant 1 or toggling every cycle
      forever begin
        @(posedge clock_clk);
        #1;
        aso_out0_ready = rdy_mode ? !aso_out0_ready : 1'b1;
      end
      // Scoreboard monitor
      forever begin
        @(negedge clock_clk);
        if (reset_reset_n && aso_out0_valid && aso_out0_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_word", 64'(aso_out0_data), 64'(0));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", 64'(aso_out0_data), 64'(e.data));
            check("out_sop", 64'(aso_out0_startofpacket), 64'(e.sop));
            check("out_eop", 64'(aso_out0_endofpacket), 64'(e.eop));
          end
        end
      end
    join_none

    // Reset state, with a stray word presented during reset
    aso_out0_ready = 1'b1;
    in_valid[0] = 1'b1;
    repeat (2) @(posedge clock_clk);
    #1;
    check_reset_outputs("reset");
    in_valid[0] = 1'b0;
    reset_reset_n = 1'b1;
    repeat (2) @(posedge clock_clk);
    #1;

    // Basic 36-word packet on channel 0
    push_exp(0, 1, PKT);
    send_pkt(0, 1, PKT);
    exp_pkt++;
    drain("basic");

    // Two ties after reset: ch0, ch1, then ch0, ch1 again
    pulse_reset();
    for (int t = 0; t < 2; t++) begin
      push_exp(0, 10 + t, PKT);
      push_exp(1, 20 + t, PKT);
      fork
        send_pkt(0, 10 + t, PKT);
        send_pkt(1, 20 + t, PKT);
      join
      exp_pkt += 2;
    end
    drain("tie");

    // Toggling output ready
    rdy_mode = 1'b1;
    push_exp(1, 30, PKT);
    send_pkt(1, 30, PKT);
    exp_pkt++;
    drain("toggle");
    rdy_mode = 1'b0;

    // Short packet (early eop), then a clean packet
    push_exp(1, 40, 10);
    send_pkt(1, 40, 10);
    exp_err++;
    drain("short");
    push_exp(1, 41, PKT);
    send_pkt(1, 41, PKT);
    exp_pkt++;
    drain("after_short");

    // Long packet: truncated at PKT words, tail flushed
    push_exp(0, 50, 40);
    send_pkt(0, 50, 40);
    exp_err++;
    drain("long");

    // Stray word on one channel, then on both at once (one increment)
    send_word(0, 32'h1234, 1'b0, 1'b0);
    release_ch(0);
    exp_err++;
    drain("stray");
    fork
      send_word(0, 32'h5678, 1'b0, 1'b0);
      send_word(1, 32'h9abc, 1'b0, 1'b0);
    join
    release_ch(0);
    release_ch(1);
    exp_err++;
    drain("stray_pair");

    // enable low blocks a grant but not a packet already in flight
    enable = 1'b0;
    push_exp(0, 60, PKT);
    fork
      send_pkt(0, 60, PKT);
      begin
        repeat (5) @(negedge clock_clk);
        check("enable_low_busy", 64'(busy), 64'(0));
        check("enable_low_ready0", 64'(in_ready[0]), 64'(0));
        @(posedge clock_clk);
        #1;
        enable = 1'b1;
        repeat (10) @(posedge clock_clk);
        #1;
        enable = 1'b0;
      end
    join
    exp_pkt++;
    drain("enable");
    enable = 1'b1;

    // err_count saturation
    for (int i = 0; i < 260; i++) send_word(0, 32'(i), 1'b0, 1'b0);
    release_ch(0);
    exp_err = 255;
    drain("saturate");

    // Reset mid-packet: abandon, then a clean packet starting with sop
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      e.data = {mk_word(0, 70, i), 1'b0};
      e.sop  = (i == 0);
      e.eop  = 1'b0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 5; i++) send_word(0, mk_word(0, 70, i), 1'(i == 0), 1'b0);
    in_data[0] = mk_word(0, 70, 5);
    in_sop[0]  = 1'b0;
    check("mid_busy_before_reset", 64'(busy), 64'(1));
    reset_reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    release_ch(0);
    repeat (2) @(posedge clock_clk);
    #1;
    reset_reset_n = 1'b1;
    repeat (2) @(posedge clock_clk);
    #1;
    exp_pkt = 0;
    exp_err = 0;
    check("mid_reset_queue", 64'(exp_q.size()), 64'(0));
    push_exp(0, 71, PKT);
    send_pkt(0, 71, PKT);
    exp_pkt++;
    drain("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
